mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM plus a 16-byte MMIO register window
// (GPIO, free-running CYCLE counter, TIMER_CMP, STATUS). Every edge
// registers the read value of the presented address into data_out.
module mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic [31:0] data_out,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        bus_error
);

    localparam int unsigned IdxW     = $clog2(MEM_WORDS);
    localparam logic [32:0] RamLimit = 33'(MEM_WORDS) << 2;
    localparam logic [32:0] MmioLo   = {1'b0, MMIO_BASE};
    localparam logic [32:0] MmioHi   = MmioLo + 33'd15;

    localparam logic [1:0] RegGpio   = 2'd0;
    localparam logic [1:0] RegCycle  = 2'd1;
    localparam logic [1:0] RegCmp    = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] data_out_q, gpio_q, gpio_d, cycle_q, cmp_q, cmp_d;
    logic        irq_q, irq_d, bus_q, bus_d;

    logic [32:0]     addr_ext;
    logic            ram_hit, mmio_hit, unmapped;
    logic [IdxW-1:0] ram_idx;
    logic [1:0]      reg_sel;
    logic [1:0]      unused_rel_lo;
    logic            status_wr, irq_match;
    logic [31:0]     rd_data;

    // Address decode; 33-bit compares keep the window test free of wrap-around.
    always_comb begin
        addr_ext = {1'b0, address};
        ram_hit  = addr_ext < RamLimit;
        mmio_hit = !ram_hit && (addr_ext >= MmioLo) && (addr_ext <= MmioHi);
        unmapped = !ram_hit && !mmio_hit;
        ram_idx  = address[IdxW+1:2];
        // Register select is the word offset from the (possibly unaligned) base.
        {reg_sel, unused_rel_lo} = address[3:0] - MMIO_BASE[3:0];
    end

    // Read mux: value the addressed location holds before this edge.
    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                RegGpio:   rd_data = gpio_q;
                RegCycle:  rd_data = cycle_q;
                RegCmp:    rd_data = cmp_q;
                RegStatus: rd_data = {30'b0, bus_q, irq_q};
                default:   rd_data = '0;
            endcase
        end
    end

    // Register next-state; flag set beats a same-cycle write-one-to-clear.
    always_comb begin
        gpio_d    = gpio_q;
        cmp_d     = cmp_q;
        status_wr = we && mmio_hit && (reg_sel == RegStatus);
        // Compare uses the pre-write TIMER_CMP and pre-increment CYCLE.
        irq_match = (cycle_q == cmp_q) && (cmp_q != 32'd0);
        irq_d     = irq_match || (irq_q && !(status_wr && data_in[0]));
        bus_d     = unmapped || (bus_q && !(status_wr && data_in[1]));
        if (we && mmio_hit && (reg_sel == RegGpio)) begin
            gpio_d = data_in;
        end
        if (we && mmio_hit && (reg_sel == RegCmp)) begin
            cmp_d = data_in;
        end
    end

    // Register state with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out_q <= '0;
            gpio_q     <= '0;
            cycle_q    <= '0;
            cmp_q      <= '0;
            irq_q      <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            data_out_q <= rd_data;
            gpio_q     <= gpio_d;
            cycle_q    <= cycle_q + 32'd1;
            cmp_q      <= cmp_d;
            irq_q      <= irq_d;
            bus_q      <= bus_d;
        end
    end

    // RAM array is never reset; same-word read in this cycle sees old data.
    always_ff @(posedge clk) begin
        if (we && ram_hit) begin
            mem[ram_idx] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign gpio_out  = gpio_q;
    assign timer_irq = irq_q;
    assign bus_error = bus_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural model predicts each
// edge's outputs into a queue; a monitor pops and compares after each edge.
module tb_mem_responder;

    localparam logic [31:0] Base  = 32'hFFFF_0000;
    localparam int unsigned Words = 1024;

    logic        clk;
    logic        resetn;
    logic [31:0] address, data_in, data_out, gpio_out;
    logic        we, timer_irq, bus_error;

    mem_responder #(
        .MEM_WORDS(Words),
        .MMIO_BASE(Base)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .gpio_out (gpio_out),
        .timer_irq(timer_irq),
        .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        bit          known;
        logic [31:0] gpio;
        logic        irq;
        logic        bus;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state
    logic [31:0] m_ram [int unsigned];
    logic [31:0] m_gpio, m_cyc, m_cmp;
    logic        m_irq, m_bus;

    task automatic model_reset();
        m_gpio = '0;
        m_cyc  = '0;
        m_cmp  = '0;
        m_irq  = 1'b0;
        m_bus  = 1'b0;
    endtask

    // Drive one access now and push the outputs expected after the next edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w);
        exp_t            e;
        longint unsigned ai;
        bit              is_ram, is_mmio, clr;
        int              off;
        int unsigned     wi;
        logic            set;
        address = a;
        data_in = d;
        we      = w;
        ai      = {32'b0, a};
        is_ram  = ai < longint'(Words) * 4;
        is_mmio = !is_ram && ai >= {32'b0, Base} && ai <= {32'b0, Base} + 15;
        off     = is_mmio ? int'((ai - {32'b0, Base}) >> 2) : 0;
        wi      = int'(ai >> 2);
        e.known = 1'b1;
        e.rd    = '0;
        if (is_ram) begin
            if (m_ram.exists(wi)) e.rd = m_ram[wi];
            else e.known = 1'b0;
        end else if (is_mmio) begin
            case (off)
                0: e.rd = m_gpio;
                1: e.rd = m_cyc;
                2: e.rd = m_cmp;
                default: e.rd = {30'b0, m_bus, m_irq};
            endcase
        end
        set   = (m_cyc == m_cmp) && (m_cmp != 0);
        clr   = w && is_mmio && off == 3;
        m_irq = set || (m_irq && !(clr && d[0]));
        m_bus = !(is_ram || is_mmio) || (m_bus && !(clr && d[1]));
        if (w && is_ram) m_ram[wi] = d;
        if (w && is_mmio && off == 0) m_gpio = d;
        if (w && is_mmio && off == 2) m_cmp = d;
        m_cyc  = m_cyc + 1;
        e.gpio = m_gpio;
        e.irq  = m_irq;
        e.bus  = m_bus;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(negedge clk);
        apply(a, d, w);
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Monitor: one registered response per edge while the scoreboard holds items.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            me = sb.pop_front();
            vectors++;
            if ((me.known && data_out !== me.rd) || gpio_out !== me.gpio ||
                timer_irq !== me.irq || bus_error !== me.bus) begin
                miscompares++;
                $display("FAIL vec%0d @%0t: data_out=%h gpio=%h irq=%b bus=%b, required data_out=%h%s gpio=%h irq=%b bus=%b",
                         vectors, $time, data_out, gpio_out, timer_irq, bus_error,
                         me.rd, me.known ? "" : "(x)", me.gpio, me.irq, me.bus);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a, d;
        logic        w;

        resetn  = 1'b0;
        address = Base;
        data_in = '0;
        we      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_now("reset data_out", data_out, 32'h0);
        check_now("reset gpio_out", gpio_out, 32'h0);
        check_now("reset timer_irq", {31'b0, timer_irq}, 32'h0);
        check_now("reset bus_error", {31'b0, bus_error}, 32'h0);

        // CYCLE reads 0 then 1 after release; then TIMER_CMP = 20 scenario.
        @(negedge clk);
        resetn = 1'b1;
        apply(Base + 4, 0, 1'b0);
        cyc(Base + 4, 0, 1'b0);
        cyc(Base + 8, 32'd20, 1'b1);
        repeat (22) cyc(Base + 12, 0, 1'b0);
        cyc(Base + 12, 32'h1, 1'b1);
        cyc(Base + 8, 32'd0, 1'b1);
        repeat (30) cyc(Base + 4, 0, 1'b0);

        // Seed part of RAM so later reads are predictable.
        for (int i = 0; i < 64; i++) cyc(i * 4, $urandom, 1'b1);

        // Basic write/read, ignored byte offset.
        cyc(32'h10, 32'h1234_5678, 1'b1);
        cyc(32'h10, 0, 1'b0);
        cyc(32'h13, 0, 1'b0);

        // Read-during-write returns old word.
        cyc(32'h20, 32'hA, 1'b1);
        cyc(32'h20, 32'hB, 1'b1);
        cyc(32'h20, 0, 1'b0);

        // Unmapped accesses and bus_error clear.
        cyc(32'h0001_0000, 0, 1'b0);
        cyc(Base + 12, 32'h2, 1'b1);
        cyc(32'h0001_0000, 32'hDEAD_BEEF, 1'b1);
        cyc(Base + 12, 32'h2, 1'b1);
        cyc(32'h10, 0, 1'b0);
        cyc(Base, 0, 1'b0);
        cyc(Base + 8, 0, 1'b0);

        // Set beats clear on the match edge.
        cyc(Base + 8, m_cyc + 3, 1'b1);
        repeat (5) cyc(Base + 12, 32'h1, 1'b1);

        // TIMER_CMP rewritten in its own match cycle: old value is compared.
        cyc(Base + 8, m_cyc + 2, 1'b1);
        cyc(Base + 12, 0, 1'b0);
        cyc(Base + 8, 32'd7, 1'b1);
        cyc(Base + 12, 0, 1'b0);
        cyc(Base + 12, 32'h1, 1'b1);
        cyc(Base + 8, 0, 1'b0);

        // Counter wrap with TIMER_CMP at all-ones.
        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFD;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFD;
        apply(Base + 4, 0, 1'b0);
        cyc(Base + 8, 32'hFFFF_FFFF, 1'b1);
        cyc(Base + 4, 0, 1'b0);
        cyc(Base + 4, 0, 1'b0);
        cyc(Base + 4, 0, 1'b0);
        cyc(Base + 12, 32'h3, 1'b1);
        cyc(Base + 8, 32'h0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 9);
            w = 1'(($urandom & 1));
            d = $urandom;
            if (r <= 3) begin
                a = ($urandom_range(0, 63) << 2) | ($urandom & 3);
            end else if (r <= 6) begin
                a = Base + ($urandom_range(0, 3) << 2) + ($urandom & 3);
                if (a[3:2] == 2'd2) d = m_cyc + 32'($urandom_range(1, 15));
                if (a[3:2] == 2'd3) d = $urandom & 3;
            end else if (r == 7) begin
                a = $urandom;
            end else if (r == 8) begin
                a = $urandom_range(0, Words - 1) << 2;
                w = 1'b1;
            end else begin
                a = Base + 12;
                w = 1'b0;
            end
            cyc(a, d, w);
        end

        // GPIO set, then asynchronous reset mid-cycle.
        cyc(Base, 32'hFF, 1'b1);
        cyc(Base + 12, 32'h3, 1'b1);
        @(posedge clk);
        #3;
        we     = 1'b0;
        resetn = 1'b0;
        #1;
        check_now("async gpio_out", gpio_out, 32'h0);
        check_now("async data_out", data_out, 32'h0);
        check_now("async timer_irq", {31'b0, timer_irq}, 32'h0);
        check_now("async bus_error", {31'b0, bus_error}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        apply(Base + 4, 0, 1'b0);
        cyc(Base + 4, 0, 1'b0);
        cyc(32'h10, 0, 1'b0);
        cyc(Base, 0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_now("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
